// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw button inputs and conditioned level/pulse outputs
interface button_conditioner_if #(parameter int N_BTN = 5);
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
   logic [N_BTN-1:0] btn_long;
   modport master (output btn_raw, input btn_level, btn_press, btn_release, btn_long);
   modport slave (input btn_raw, output btn_level, btn_press, btn_release, btn_long);
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: per-button 2-flop sync, counter debounce, and registered
// press/release/long-press pulses in the system clock domain
module button_conditioner #(
   parameter int N_BTN       = 5,
   parameter int DB_CYCLES   = 1000000,
   parameter int HOLD_CYCLES = 100000000
) (
   input  logic                 clock,
   input  logic                 reset_n,
   button_conditioner_if.slave  btn
);
   localparam int DW = $clog2(DB_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
   logic [N_BTN-1:0] s1, s2;
   logic [N_BTN-1:0] level_v, press_v, release_v, long_v;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= btn.btn_raw;
         s2 <= s1;
      end
   end
   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      state_t        st, st_nx;
      logic [DW-1:0] db_cnt, db_nx;
      logic [HW-1:0] hold_cnt, hold_nx;
      logic          press_q, release_q, long_q;
      logic          press_nx, release_nx, long_nx;
      logic          lvl, differ, flip;
      // The FSM state is the debounced level: anything but IDLE means pressed.
      assign lvl    = st != IDLE;
      assign differ = s2[i] != lvl;
      assign flip   = differ && db_cnt == DW'(DB_CYCLES - 1);
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            st        <= IDLE;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
         end else begin
            st        <= st_nx;
            db_cnt    <= db_nx;
            hold_cnt  <= hold_nx;
            press_q   <= press_nx;
            release_q <= release_nx;
            long_q    <= long_nx;
         end
      end
      always_comb begin
         st_nx      = st;
         hold_nx    = '0;
         press_nx   = 1'b0;
         release_nx = 1'b0;
         long_nx    = 1'b0;
         db_nx      = (differ && !flip) ? db_cnt + 1'b1 : '0;
         case (st)
            IDLE: begin
               st_nx    = flip ? PRESSED : IDLE;
               press_nx = flip;
            end
            PRESSED: begin
               hold_nx    = hold_cnt + 1'b1;
               long_nx    = hold_cnt == HW'(HOLD_CYCLES - 1);
               st_nx      = flip ? IDLE : (long_nx ? HELD : PRESSED);
               release_nx = flip;
            end
            HELD: begin
               hold_nx    = hold_cnt;
               st_nx      = flip ? IDLE : HELD;
               release_nx = flip;
            end
            default: st_nx = IDLE;
         endcase
      end
      assign level_v[i]   = lvl;
      assign press_v[i]   = press_q;
      assign release_v[i] = release_q;
      assign long_v[i]    = long_q;
   end
   assign btn.btn_level   = level_v;
   assign btn.btn_press   = press_v;
   assign btn.btn_release = release_v;
   assign btn.btn_long    = long_v;
endmodule
